// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, streams word requests to instruction memory,
// buffers responses and hands {instr, pc, pc4} to decode with stall/flush support.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        flush_ip,
  input  logic [31:0] redirect_pc_ip,
  input  logic        redirect_jalr_ip,
  output logic        imem_req_op,
  output logic [31:0] imem_addr_op,
  input  logic        imem_ready_ip,
  input  logic        imem_rvalid_ip,
  input  logic [31:0] imem_rdata_ip,
  output logic        instr_data_valid_op,
  output logic [31:0] instr_data_op,
  output logic [31:0] pc_op,
  output logic [31:0] pc4_op,
  output logic        misalign_op
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [0:0]  RUN   = 1'b0;
  localparam logic [0:0]  DRAIN = 1'b1;

  function automatic logic [31:0] redirect_target(input logic [31:0] pc, input logic jalr);
    redirect_target = pc & ~{31'b0, jalr};
  endfunction

  logic [0:0]    state;
  logic [31:0]   fetch_pc, resp_pc, target;
  logic [CW-1:0] count, outstanding, drop_cnt, inflight_left, drop_after;
  logic [CW:0]   used;
  logic [PW-1:0] head, tail;
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic          accept, drop_word, push, pop;

  assign target = redirect_target(redirect_pc_ip, redirect_jalr_ip);

  // Kept and to-be-dropped in-flight words both reserve a slot, so the buffer cannot overflow.
  assign used         = {1'b0, count} + {1'b0, outstanding} + {1'b0, drop_cnt};
  assign imem_req_op  = reset && !flush_ip && (used < (CW+1)'(BUF_DEPTH));
  assign imem_addr_op = fetch_pc;
  assign accept       = imem_req_op && imem_ready_ip;

  assign drop_word = imem_rvalid_ip && (state == DRAIN);
  assign push      = reset && !flush_ip && imem_rvalid_ip && !drop_word;
  assign pop       = !flush_ip && !stall_ip && (count != '0);

  // Words still owed by memory after this edge; all of them become stale on reset/flush.
  assign inflight_left = drop_cnt + outstanding - CW'(imem_rvalid_ip);
  assign drop_after    = drop_cnt - CW'(drop_word);

  // Request/response bookkeeping and buffer pointers
  always_ff @(posedge clock) begin
    if (!reset || flush_ip) begin
      outstanding <= '0;
      drop_cnt    <= inflight_left;
      state       <= (inflight_left != '0) ? DRAIN : RUN;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid_ip && !drop_word);
      drop_cnt    <= drop_after;
      state       <= (drop_after != '0) ? DRAIN : RUN;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (flush_ip) begin
      fetch_pc <= {target[31:2], 2'b00};
      resp_pc  <= {target[31:2], 2'b00};
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (push)   resp_pc  <= resp_pc + 32'd4;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_instr[tail] <= imem_rdata_ip;
      buf_pc[tail]    <= resp_pc;
    end
  end

  // Decode-facing register stage
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_data_valid_op <= 1'b0;
      instr_data_op       <= NOP;
      pc_op               <= '0;
      pc4_op              <= '0;
      misalign_op         <= 1'b0;
    end else begin
      misalign_op <= flush_ip && (target[1:0] != 2'b00);
      if (flush_ip) begin
        instr_data_valid_op <= 1'b0;
        instr_data_op       <= NOP;
      end else if (!stall_ip) begin
        if (count != '0) begin
          instr_data_valid_op <= 1'b1;
          instr_data_op       <= buf_instr[head];
          pc_op               <= buf_pc[head];
          pc4_op              <= buf_pc[head] + 32'd4;
        end else begin
          instr_data_valid_op <= 1'b0;
          instr_data_op       <= NOP;
        end
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model returning ~addr as the
// instruction word, with per-cycle checks of the decode-facing stream.
module tb_if_fetch_unit;
  logic        clock, reset, stall_ip, flush_ip, redirect_jalr_ip;
  logic        imem_ready_ip, imem_rvalid_ip;
  logic [31:0] redirect_pc_ip, imem_rdata_ip;
  logic        imem_req_op, instr_data_valid_op, misalign_op;
  logic [31:0] imem_addr_op, instr_data_op, pc_op, pc4_op;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] saved_addr;
  logic [31:0] q_addr[$];
  int          q_due[$];

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .stall_ip(stall_ip), .flush_ip(flush_ip),
    .redirect_pc_ip(redirect_pc_ip), .redirect_jalr_ip(redirect_jalr_ip),
    .imem_req_op(imem_req_op), .imem_addr_op(imem_addr_op), .imem_ready_ip(imem_ready_ip),
    .imem_rvalid_ip(imem_rvalid_ip), .imem_rdata_ip(imem_rdata_ip),
    .instr_data_valid_op(instr_data_valid_op), .instr_data_op(instr_data_op),
    .pc_op(pc_op), .pc4_op(pc4_op), .misalign_op(misalign_op)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive the memory response, record the handshake, then check the stream.
  task automatic tick();
    logic s_rst, s_stall, s_flush, p_vld;
    logic [31:0] p_pc, p_pc4, p_ins;
    imem_rvalid_ip = 1'b0;
    imem_rdata_ip  = 32'h0;
    if (q_addr.size() > 0 && q_due[0] <= cyc + 1) begin
      imem_rvalid_ip = 1'b1;
      imem_rdata_ip  = ~q_addr[0];
    end
    #1;
    s_rst = reset; s_stall = stall_ip; s_flush = flush_ip;
    p_vld = instr_data_valid_op; p_pc = pc_op; p_pc4 = pc4_op; p_ins = instr_data_op;
    if (imem_req_op && imem_ready_ip) begin
      q_addr.push_back(imem_addr_op);
      q_due.push_back(cyc + 1 + lat);
    end
    @(posedge clock);
    cyc++;
    if (imem_rvalid_ip) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    #1;
    if (s_rst) begin
      if (s_flush) begin
        chk("flush_vld", 32'(instr_data_valid_op), 32'd0);
        chk("flush_nop", instr_data_op, 32'h0000_0013);
      end else if (s_stall) begin
        chk("stall_vld", 32'(instr_data_valid_op), 32'(p_vld));
        chk("stall_pc", pc_op, p_pc);
        chk("stall_pc4", pc4_op, p_pc4);
        chk("stall_ins", instr_data_op, p_ins);
      end else if (instr_data_valid_op) begin
        chk("seq_pc", pc_op, exp_pc);
        chk("seq_ins", instr_data_op, ~exp_pc);
        chk("seq_pc4", pc4_op, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  initial begin
    reset = 1'b0; stall_ip = 1'b0; flush_ip = 1'b0;
    redirect_pc_ip = 32'h0; redirect_jalr_ip = 1'b0;
    imem_ready_ip = 1'b1; imem_rvalid_ip = 1'b0; imem_rdata_ip = 32'h0;

    // Reset values, then first fetch latency and a sequential stream
    tick(); tick();
    chk("rst_req", 32'(imem_req_op), 32'd0);
    chk("rst_addr", imem_addr_op, 32'h0);
    chk("rst_vld", 32'(instr_data_valid_op), 32'd0);
    chk("rst_ins", instr_data_op, 32'h0000_0013);
    chk("rst_pc", pc_op, 32'h0);
    chk("rst_pc4", pc4_op, 32'h0);
    chk("rst_mis", 32'(misalign_op), 32'd0);
    reset = 1'b1; exp_pc = 32'h0;
    tick();
    chk("t1_vld_e1", 32'(instr_data_valid_op), 32'd0);
    chk("t1_addr_e1", imem_addr_op, 32'h4);
    tick();
    chk("t1_vld_e2", 32'(instr_data_valid_op), 32'd0);
    tick();
    chk("t1_vld_e3", 32'(instr_data_valid_op), 32'd1);
    chk("t1_pc_e3", pc_op, 32'h0);
    repeat (8) tick();

    // Stall mid-stream: outputs freeze, buffer fills, stream stays contiguous
    stall_ip = 1'b1;
    repeat (3) tick();
    chk("t2_req_full", 32'(imem_req_op), 32'd0);
    stall_ip = 1'b0;
    repeat (8) tick();
    chk("t2_progress", 32'(exp_pc > 32'h20), 32'd1);

    // Flush with two fetches in flight
    lat = 3;
    for (int i = 0; i < 20 && q_addr.size() != 2; i++) tick();
    chk("t3_two_inflight", 32'(q_addr.size()), 32'd2);
    flush_ip = 1'b1; redirect_pc_ip = 32'h100; redirect_jalr_ip = 1'b0;
    #1;
    chk("t3_req_flush", 32'(imem_req_op), 32'd0);
    tick();
    flush_ip = 1'b0; exp_pc = 32'h100;
    chk("t3_vld_after", 32'(instr_data_valid_op), 32'd0);
    chk("t3_addr", imem_addr_op, 32'h100);
    chk("t3_mis", 32'(misalign_op), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("t3_progress", 32'(exp_pc > 32'h100), 32'd1);

    // JALR redirect to a misaligned target
    flush_ip = 1'b1; redirect_pc_ip = 32'h203; redirect_jalr_ip = 1'b1;
    tick();
    flush_ip = 1'b0; redirect_jalr_ip = 1'b0; exp_pc = 32'h200;
    chk("t4_mis_pulse", 32'(misalign_op), 32'd1);
    chk("t4_addr", imem_addr_op, 32'h200);
    tick();
    chk("t4_mis_clear", 32'(misalign_op), 32'd0);
    repeat (12) tick();
    chk("t4_progress", 32'(exp_pc > 32'h200), 32'd1);

    // Memory not ready: request held stable; then PC wrap past 0xFFFF_FFFC
    for (int i = 0; i < 20 && !imem_req_op; i++) tick();
    chk("t5_req_before", 32'(imem_req_op), 32'd1);
    imem_ready_ip = 1'b0; saved_addr = imem_addr_op;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_req_hold", 32'(imem_req_op), 32'd1);
      chk("t5_addr_hold", imem_addr_op, saved_addr);
    end
    imem_ready_ip = 1'b1;
    flush_ip = 1'b1; redirect_pc_ip = 32'hFFFF_FFF8;
    tick();
    flush_ip = 1'b0; exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 30 && exp_pc != 32'h8; i++) tick();
    chk("t5_wrap", exp_pc, 32'h8);

    // Reset with one late response in flight
    stall_ip = 1'b1;
    for (int i = 0; i < 10 && q_addr.size() != 0; i++) tick();
    stall_ip = 1'b0; flush_ip = 1'b1; redirect_pc_ip = 32'h400;
    tick();
    flush_ip = 1'b0; exp_pc = 32'h400;
    tick();
    chk("t6_one_inflight", 32'(q_addr.size()), 32'd1);
    reset = 1'b0;
    tick();
    chk("t6_rst_req", 32'(imem_req_op), 32'd0);
    chk("t6_rst_addr", imem_addr_op, 32'h0);
    chk("t6_rst_vld", 32'(instr_data_valid_op), 32'd0);
    chk("t6_rst_pc", pc_op, 32'h0);
    chk("t6_rst_ins", instr_data_op, 32'h0000_0013);
    reset = 1'b1; exp_pc = 32'h0;
    for (int i = 0; i < 12; i++) tick();
    chk("t6_progress", 32'(exp_pc > 32'h0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
